// File: rtl/perf_counter_ctrl.sv
// ---------------------------------------------------------------------------
// perf_counter_ctrl
//
// Purpose:
//   Controller and scheduler for a bank of event counters used for core
//   performance monitoring. Each slot picks one bit of the shared event bus.
//   Software starts, stops, clears and re-targets a slot through a one-per-
//   cycle command port. A slot runs free (window 0) or for a fixed number of
//   cycles, after which it freezes and raises a level done flag. A registered
//   read port returns a slot's value and status.
//
// Ports:
//   clk        in   core clock, all state changes on posedge
//   reset_n    in   synchronous active-low reset
//   event_in   in   [NUM_EVENTS] per-cycle event levels
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (low during and one cycle after reset)
//   cmd_op     in   [2] 0=SELECT 1=START 2=STOP 3=CLEAR
//   cmd_index  in   target slot
//   cmd_arg    in   [COUNTER_WIDTH] SELECT: event index, START: window length
//   rd_en      in   read request
//   rd_index   in   slot to read
//   rd_valid   out  read data valid, one cycle after rd_en
//   rd_value   out  [COUNTER_WIDTH] value of the slot read
//   rd_status  out  [4] {overflow, done, state[1:0]} of the slot read
//   done_irq   out  [NUM_COUNTERS] per-slot level done flag
// ---------------------------------------------------------------------------
module perf_counter_ctrl #(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_EVENTS-1:0]           event_in,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [$clog2(NUM_COUNTERS)-1:0] cmd_index,
  input  logic [COUNTER_WIDTH-1:0]        cmd_arg,
  input  logic                            rd_en,
  input  logic [$clog2(NUM_COUNTERS)-1:0] rd_index,
  output logic                            rd_valid,
  output logic [COUNTER_WIDTH-1:0]        rd_value,
  output logic [3:0]                      rd_status,
  output logic [NUM_COUNTERS-1:0]         done_irq
);

  localparam int IDX_W = $clog2(NUM_COUNTERS);
  localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  localparam logic [1:0] OP_SELECT = 2'd0;
  localparam logic [1:0] OP_START  = 2'd1;
  localparam logic [1:0] OP_STOP   = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] EV_LIMIT = COUNTER_WIDTH'(NUM_EVENTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Per-slot state
  state_e                   state_q  [NUM_COUNTERS];
  state_e                   state_d  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] value_q  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] value_d  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] window_q [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] window_d [NUM_COUNTERS];
  logic [SEL_W-1:0]         sel_q    [NUM_COUNTERS];
  logic [SEL_W-1:0]         sel_d    [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  ovf_q;
  logic [NUM_COUNTERS-1:0]  ovf_d;
  logic [NUM_COUNTERS-1:0]  done_q;
  logic [NUM_COUNTERS-1:0]  done_d;

  // Command / read port state
  logic                     cmd_ready_q;
  logic                     cmd_ready_d;
  logic                     rd_valid_q;
  logic                     rd_valid_d;
  logic [COUNTER_WIDTH-1:0] rd_value_q;
  logic [COUNTER_WIDTH-1:0] rd_value_d;
  logic [3:0]               rd_status_q;
  logic [3:0]               rd_status_d;

  // Decoded per-slot command hit
  logic [NUM_COUNTERS-1:0]  cmd_hit_s;
  logic                     cmd_accept_s;
  logic                     arg_sel_ok_s;

  assign cmd_accept_s = cmd_valid && cmd_ready_q;
  // Out-of-range SELECT arguments are accepted but leave the select alone.
  assign arg_sel_ok_s = (cmd_arg < EV_LIMIT);

  // Decode which slot the accepted command targets.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cmd_hit_s[i] = cmd_accept_s && (cmd_index == IDX_W'(i));
    end
  end

  // State register plus all datapath and read-port flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        state_q[i]  <= ST_IDLE;
        value_q[i]  <= CNT_ZERO;
        window_q[i] <= CNT_ZERO;
        sel_q[i]    <= {SEL_W{1'b0}};
      end
      ovf_q       <= {NUM_COUNTERS{1'b0}};
      done_q      <= {NUM_COUNTERS{1'b0}};
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_value_q  <= CNT_ZERO;
      rd_status_q <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        state_q[i]  <= state_d[i];
        value_q[i]  <= value_d[i];
        window_q[i] <= window_d[i];
        sel_q[i]    <= sel_d[i];
      end
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_value_q  <= rd_value_d;
      rd_status_q <= rd_status_d;
    end
  end

  // Next-state logic: a command to the slot outranks window expiry.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      state_d[i] = state_q[i];
      if (cmd_hit_s[i] && (cmd_op == OP_START)) begin
        state_d[i] = ST_RUN;
      end else if (cmd_hit_s[i] && (cmd_op == OP_STOP)) begin
        // STOP only leaves RUN; IDLE and DONE are unaffected.
        if (state_q[i] == ST_RUN) begin
          state_d[i] = ST_IDLE;
        end else begin
          state_d[i] = state_q[i];
        end
      end else if (cmd_hit_s[i] && (cmd_op == OP_CLEAR)) begin
        state_d[i] = ST_IDLE;
      end else if ((state_q[i] == ST_RUN) && (window_q[i] == CNT_ONE)) begin
        state_d[i] = ST_DONE;
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Per-slot datapath: value, window, select, overflow and done flags.
  always_comb begin
    logic count_en;
    logic ev_bit;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      value_d[i]  = value_q[i];
      window_d[i] = window_q[i];
      sel_d[i]    = sel_q[i];
      ovf_d[i]    = ovf_q[i];
      done_d[i]   = done_q[i];
      ev_bit      = event_in[sel_q[i]];
      count_en    = (state_q[i] == ST_RUN);

      if (cmd_hit_s[i]) begin
        case (cmd_op)
          OP_SELECT: begin
            // The new select applies from the next cycle; this cycle still
            // counts on the old source.
            if (arg_sel_ok_s) begin
              sel_d[i] = cmd_arg[SEL_W-1:0];
            end else begin
              sel_d[i] = sel_q[i];
            end
          end
          OP_START: begin
            // Value is kept so a START resumes; events this cycle are ignored.
            count_en    = 1'b0;
            window_d[i] = cmd_arg;
            ovf_d[i]    = 1'b0;
            done_d[i]   = 1'b0;
          end
          OP_STOP: begin
            count_en = 1'b0;
          end
          OP_CLEAR: begin
            count_en    = 1'b0;
            value_d[i]  = CNT_ZERO;
            window_d[i] = CNT_ZERO;
            ovf_d[i]    = 1'b0;
            done_d[i]   = 1'b0;
          end
          default: begin
            count_en = 1'b0;
          end
        endcase
      end else begin
        count_en = (state_q[i] == ST_RUN);
      end

      if (count_en) begin
        if (ev_bit) begin
          value_d[i] = value_q[i] + CNT_ONE;
          // Sticky overflow on wrap from all-ones; counting carries on.
          if (&value_q[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            ovf_d[i] = ovf_q[i];
          end
        end else begin
          value_d[i] = value_q[i];
        end
        // A nonzero window ticks down every running cycle, events or not.
        if (window_q[i] != CNT_ZERO) begin
          window_d[i] = window_q[i] - CNT_ONE;
          if (window_q[i] == CNT_ONE) begin
            done_d[i] = 1'b1;
          end else begin
            done_d[i] = done_q[i];
          end
        end else begin
          window_d[i] = window_q[i];
        end
      end else begin
        ev_bit = 1'b0;
      end
    end
  end

  // Command-ready and read-port next values; reads see pre-edge slot state.
  always_comb begin
    cmd_ready_d = 1'b1;
    rd_valid_d  = rd_en;
    rd_value_d  = rd_value_q;
    rd_status_d = rd_status_q;
    if (rd_en) begin
      rd_value_d  = value_q[rd_index];
      rd_status_d = {ovf_q[rd_index], done_q[rd_index], state_q[rd_index]};
    end else begin
      rd_value_d  = rd_value_q;
      rd_status_d = rd_status_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_value  = rd_value_q;
  assign rd_status = rd_status_q;
  assign done_irq  = done_q;

endmodule

// File: doc/perf_counter_ctrl.md
Name: perf_counter_ctrl

Overview:
- Controller and scheduler for a bank of event counters used for core performance monitoring.
- Each counter slot selects one event source from a shared event bus, and software starts, stops and clears it through a command port.
- A slot can run free or for a fixed cycle window, then freeze and raise a done flag.
- A registered read port returns counter values and status to the control-register block.

Parameters:
NUM_COUNTERS, 4, number of counter slots
NUM_EVENTS, 8, width of event input bus
COUNTER_WIDTH, 32, width of each counter value and window length

Ports:
clk  in  1  core clock; all state changes on posedge
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
event_in  in  NUM_EVENTS  per-cycle event pulses, level-sampled each posedge
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted
cmd_op  in  2  0=SELECT, 1=START, 2=STOP, 3=CLEAR
cmd_index  in  $clog2(NUM_COUNTERS)  target counter slot
cmd_arg  in  COUNTER_WIDTH  SELECT: event index; START: window length (0 = free-running); else ignored
rd_en  in  1  read request
rd_index  in  $clog2(NUM_COUNTERS)  slot to read
rd_valid  out  1  read data valid, one cycle after rd_en
rd_value  out  COUNTER_WIDTH  counter value of slot read
rd_status  out  4  {overflow, done, state[1:0]} of slot read
done_irq  out  NUM_COUNTERS  per-slot level done flag

Behaviour:
- Reset: when reset_n is low at a posedge, the following clear. All values 0, all event selects 0, all windows 0, all states IDLE, overflow 0, done_irq 0, rd_valid 0, rd_value 0, rd_status 0, cmd_ready 0. Reset mid-run aborts all counting with no partial effects.
- cmd_ready: 0 while reset_n is low and for the first cycle after deassertion, then 1 permanently. A command is accepted on a posedge with cmd_valid && cmd_ready, at most one per cycle.
- Per-slot state: IDLE=0, RUN=1, DONE=2.
  - START: any state -> RUN. Loads window=cmd_arg and clears done and overflow. The value is NOT cleared, so START resumes.
  - STOP: RUN -> IDLE. In IDLE or DONE it has no effect.
  - CLEAR: any state -> IDLE. Zeroes value, window, overflow and done.
  - SELECT: updates the event select in any state; takes effect the cycle after acceptance. If cmd_arg >= NUM_EVENTS, the select is unchanged but the command is still accepted.
- Counting:
  - On each posedge, a slot in RUN that is not targeted by an accepted START/STOP/CLEAR that cycle adds event_in[sel] to its value.
  - Events in the cycle a START is accepted are not counted; counting begins the next cycle.
  - Events in the cycle a STOP or CLEAR is accepted are dropped.
- Wrap: on value all-ones +1 the value wraps to 0 and the sticky overflow flag is set. Overflow does not stop counting.
- Window (window != 0):
  - Decrements by 1 each RUN cycle, regardless of events.
  - The cycle window==1 is the last counting cycle; at that posedge the window becomes 0, state -> DONE and done_irq[i] -> 1.
  - A START with window N counts events on exactly N cycles.
  - With window==0 the slot runs until STOP or CLEAR.
- Simultaneous events: an accepted command to a slot has priority over window expiry in the same cycle (e.g. a STOP on the last window cycle -> IDLE, done stays 0). Commands to slot i never affect slot j.
- DONE freezes value and window. done_irq[i] stays high until START or CLEAR of slot i.
- Read port:
  - On a posedge with rd_en, rd_value and rd_status capture slot rd_index's pre-edge value, and rd_valid=1 next cycle.
  - Without rd_en, rd_valid=0 and the data outputs hold.
  - A read and a command to the same slot in one cycle return the pre-command value.

Test Plan:
- Reset then SELECT slot0 ev 2, START window 0; drive event_in[2] high for 10 cycles, then STOP; read slot0 -> rd_value=10, status state=IDLE, overflow=0.
- START slot1 window 5 with ev 0 held high -> after 5 cycles rd_value=5, state=DONE, done_irq=4'b0010; further events leave value 5; CLEAR -> value 0, done_irq=0.
- Preload by counting with COUNTER_WIDTH=4 from 0 through 16 events -> value wraps to 0, overflow=1; START clears overflow but keeps value 0.
- START slot2 window 3, issue STOP in the third run cycle -> state=IDLE, done_irq[2]=0, value counts only the first 2 cycles' events.
- Slots 0 and 3 run concurrently on different events, with SELECT to slot 0 of event index 9 (invalid) -> slot 0 select unchanged, slot 3 unaffected; reset_n low mid-run -> all values 0, cmd_ready 0 for one cycle after release.
- Read slot in the same cycle as CLEAR -> rd_value returns the old value; a read the next cycle returns 0; rd_valid is a single-cycle pulse per rd_en.
